foc_sample_sequencer: RTL and testbench

Acquisition front end for the field-oriented-control pipeline. On each PWM period trigger it latches the resolver angle and sequences three phase-current conversions through a shared ADC handshake. It converts the offset-binary codes to signed, offset-corrected, full-scale `D_WIDTH` values and presents the phase currents and the angle to the FOC top with a valid/ready handshake. Its outputs connect directly to the top's `angle_in`, `currA_in`, `currB_in`, `currC_in`, `valid` and `ready`.

---
 rtl/foc_pkg.sv | 29 ++
 rtl/foc_sample_sequencer_if.sv | 28 ++
 rtl/offset_accumulator.sv | 53 +++++
 rtl/foc_sample_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_foc_sample_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/foc_pkg.sv
// rtl/foc_pkg.sv - shared types, channel codes and code-to-current scaling for the FOC sample sequencer
package foc_pkg;

  typedef enum logic [2:0] {
    ST_CAL,
    ST_IDLE,
    ST_CONV,
    ST_CALC,
    ST_PRESENT
  } seq_state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;

  // Offset-binary code -> signed, offset-corrected, saturated, left-justified current.
  function automatic int adc_to_q(input int code, input int offset, input int adc_w, input int d_w);
    int half;
    int d;
    half = 1 << (adc_w - 1);
    d = code - half - offset;
    if (d > half - 1)
      d = half - 1;
    else if (d < -half)
      d = -half;
    return d <<< (d_w - adc_w);
  endfunction

endpackage

// File: rtl/foc_sample_sequencer_if.sv
// rtl/foc_sample_sequencer_if.sv - ADC handshake and sample-set output bundle of the FOC sample sequencer
interface foc_sample_sequencer_if #(
  parameter int D_WIDTH   = 16,
  parameter int ADC_WIDTH = 12
);

  logic                        adc_req;
  logic [1:0]                  adc_ch;
  logic                        adc_ack;
  logic [ADC_WIDTH-1:0]        adc_data;
  logic [D_WIDTH-1:0]          angle_out;
  logic signed [D_WIDTH-1:0]   currA_out;
  logic signed [D_WIDTH-1:0]   currB_out;
  logic signed [D_WIDTH-1:0]   currC_out;
  logic                        valid_out;
  logic                        ready_in;

  modport master (
    output adc_req, adc_ch, angle_out, currA_out, currB_out, currC_out, valid_out,
    input  adc_ack, adc_data, ready_in
  );

  modport slave (
    input  adc_req, adc_ch, angle_out, currA_out, currB_out, currC_out, valid_out,
    output adc_ack, adc_data, ready_in
  );

endinterface

// File: rtl/offset_accumulator.sv
// rtl/offset_accumulator.sv - per-channel calibration accumulators with round counter (used with OFFSET_CAL_EN)
module offset_accumulator
  import foc_pkg::*;
#(
  parameter int S_WIDTH  = 13,
  parameter int CAL_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      sample_valid,
  input  logic [1:0]                sample_ch,
  input  logic signed [S_WIDTH-1:0] sample,
  output logic signed [S_WIDTH-1:0] offset_a,
  output logic signed [S_WIDTH-1:0] offset_b,
  output logic signed [S_WIDTH-1:0] offset_c,
  output logic                      last_round,
  output logic                      done
);

  localparam int ACC_W = S_WIDTH + CAL_LOG2;

  logic signed [ACC_W-1:0] acc_a, acc_b, acc_c;
  logic [CAL_LOG2:0]       rounds;

  assign last_round = (rounds == (CAL_LOG2 + 1)'((1 << CAL_LOG2) - 1));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      acc_a  <= '0;
      acc_b  <= '0;
      acc_c  <= '0;
      rounds <= '0;
      done   <= 1'b0;
    end else if (sample_valid && !done) begin
      case (sample_ch)
        CH_A:    acc_a <= acc_a + ACC_W'(sample);
        CH_B:    acc_b <= acc_b + ACC_W'(sample);
        default: acc_c <= acc_c + ACC_W'(sample);
      endcase
      // A round completes on the channel C sample.
      if (sample_ch == CH_C) begin
        rounds <= rounds + 1'b1;
        if (last_round)
          done <= 1'b1;
      end
    end
  end

  assign offset_a = S_WIDTH'(acc_a >>> CAL_LOG2);
  assign offset_b = S_WIDTH'(acc_b >>> CAL_LOG2);
  assign offset_c = S_WIDTH'(acc_c >>> CAL_LOG2);

endmodule

// File: rtl/foc_sample_sequencer.sv
// rtl/foc_sample_sequencer.sv - FOC acquisition front end: angle latch, 3-phase ADC sequencing, offset correction
// Optional startup offset calibration is built when OFFSET_CAL_EN is defined.
module foc_sample_sequencer
  import foc_pkg::*;
#(
  parameter int D_WIDTH   = 16,
  parameter int ADC_WIDTH = 12,
  parameter int CAL_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 trigger,
  input  logic [D_WIDTH-1:0]   angle_in,
  foc_sample_sequencer_if.master bus,
  output logic                 overrun,
  output logic                 cal_done
);

`ifdef OFFSET_CAL_EN
  localparam seq_state_t RST_STATE = ST_CAL;
  localparam logic       CAL_RST   = 1'b0;
`else
  localparam seq_state_t RST_STATE = ST_IDLE;
  localparam logic       CAL_RST   = 1'b1;
  localparam int         unused_cal_log2 = CAL_LOG2;
`endif

  seq_state_t                state, state_n;
  logic                      req_q, req_n;
  logic [1:0]                ch_q, ch_n;
  logic [ADC_WIDTH-1:0]      code_a, code_b, code_c;
  logic [ADC_WIDTH-1:0]      code_a_n, code_b_n, code_c_n;
  logic [D_WIDTH-1:0]        angle_q, angle_n;
  logic signed [D_WIDTH-1:0] a_q, b_q, c_q, a_n, b_n, c_n;
  logic                      valid_q, valid_n;
  logic                      ovr_q, ovr_n;
  logic                      cal_q, cal_n;
  logic signed [ADC_WIDTH:0] off_a, off_b, off_c;
  logic                      capture;

  // Acks arriving with no request outstanding are ignored here.
  assign capture = req_q && bus.adc_ack;

`ifdef OFFSET_CAL_EN
  logic signed [ADC_WIDTH:0] adc_s;
  logic                      acc_last, acc_done;

  assign adc_s = $signed({1'b0, bus.adc_data}) - $signed({2'b01, {(ADC_WIDTH-1){1'b0}}});

  offset_accumulator #(
    .S_WIDTH  (ADC_WIDTH + 1),
    .CAL_LOG2 (CAL_LOG2)
  ) u_offset_acc (
    .clk          (clk),
    .rstb         (rstb),
    .sample_valid (state == ST_CAL && capture),
    .sample_ch    (ch_q),
    .sample       (adc_s),
    .offset_a     (off_a),
    .offset_b     (off_b),
    .offset_c     (off_c),
    .last_round   (acc_last),
    .done         (acc_done)
  );
`else
  assign off_a = '0;
  assign off_b = '0;
  assign off_c = '0;
`endif

  always_comb begin
    state_n  = state;
    req_n    = req_q;
    ch_n     = ch_q;
    code_a_n = code_a;
    code_b_n = code_b;
    code_c_n = code_c;
    angle_n  = angle_q;
    a_n      = a_q;
    b_n      = b_q;
    c_n      = c_q;
    valid_n  = valid_q;
    ovr_n    = ovr_q;
    cal_n    = cal_q;
    case (state)
`ifdef OFFSET_CAL_EN
      ST_CAL: begin
        if (acc_done) begin
          req_n   = 1'b0;
          ch_n    = CH_A;
          cal_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (!req_q) begin
          req_n = 1'b1;
          ch_n  = CH_A;
        end else if (capture) begin
          if (ch_q == CH_C) begin
            ch_n  = CH_A;
            req_n = !acc_last;
          end else begin
            ch_n = ch_q + 2'd1;
          end
        end
      end
`endif
      ST_IDLE: begin
        if (trigger) begin
          angle_n = angle_in;
          ch_n    = CH_A;
          req_n   = 1'b1;
          state_n = ST_CONV;
        end
      end
      ST_CONV: begin
        if (trigger)
          ovr_n = 1'b1;
        if (capture) begin
          case (ch_q)
            CH_A:    code_a_n = bus.adc_data;
            CH_B:    code_b_n = bus.adc_data;
            default: code_c_n = bus.adc_data;
          endcase
          if (ch_q == CH_C) begin
            req_n   = 1'b0;
            state_n = ST_CALC;
          end else begin
            ch_n = ch_q + 2'd1;
          end
        end
      end
      ST_CALC: begin
        if (trigger)
          ovr_n = 1'b1;
        a_n     = D_WIDTH'(adc_to_q(int'(code_a), int'(off_a), ADC_WIDTH, D_WIDTH));
        b_n     = D_WIDTH'(adc_to_q(int'(code_b), int'(off_b), ADC_WIDTH, D_WIDTH));
        c_n     = D_WIDTH'(adc_to_q(int'(code_c), int'(off_c), ADC_WIDTH, D_WIDTH));
        valid_n = 1'b1;
        state_n = ST_PRESENT;
      end
      ST_PRESENT: begin
        // A trigger coinciding with the transfer still counts as overrun.
        if (trigger)
          ovr_n = 1'b1;
        if (bus.ready_in) begin
          valid_n = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state   <= RST_STATE;
      req_q   <= 1'b0;
      ch_q    <= CH_A;
      code_a  <= '0;
      code_b  <= '0;
      code_c  <= '0;
      angle_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cal_q   <= CAL_RST;
    end else begin
      state   <= state_n;
      req_q   <= req_n;
      ch_q    <= ch_n;
      code_a  <= code_a_n;
      code_b  <= code_b_n;
      code_c  <= code_c_n;
      angle_q <= angle_n;
      a_q     <= a_n;
      b_q     <= b_n;
      c_q     <= c_n;
      valid_q <= valid_n;
      ovr_q   <= ovr_n;
      cal_q   <= cal_n;
    end
  end

  assign bus.adc_req   = req_q;
  assign bus.adc_ch    = ch_q;
  assign bus.angle_out = angle_q;
  assign bus.currA_out = a_q;
  assign bus.currB_out = b_q;
  assign bus.currC_out = c_q;
  assign bus.valid_out = valid_q;
  assign overrun       = ovr_q;
  assign cal_done      = cal_q;

endmodule

// File: tb/tb_foc_sample_sequencer.sv
// tb/tb_foc_sample_sequencer.sv - randomized self-checking bench for foc_sample_sequencer against an arithmetic model
module tb_foc_sample_sequencer;

  localparam int D_W = 16;
  localparam int A_W = 12;
  localparam int C_L = 4;
`ifdef OFFSET_CAL_EN
  localparam bit CAL_RST_EXP = 1'b0;
`else
  localparam bit CAL_RST_EXP = 1'b1;
`endif

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic           trigger = 1'b0;
  logic [D_W-1:0] angle_in = '0;
  logic           overrun;
  logic           cal_done;

  foc_sample_sequencer_if #(.D_WIDTH(D_W), .ADC_WIDTH(A_W)) bus ();

  foc_sample_sequencer #(
    .D_WIDTH   (D_W),
    .ADC_WIDTH (A_W),
    .CAL_LOG2  (C_L)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .trigger  (trigger),
    .angle_in (angle_in),
    .bus      (bus),
    .overrun  (overrun),
    .cal_done (cal_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_code [3];
  int model_off [3] = '{0, 0, 0};
  int ack_wait = 0;
  bit exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: subtract mid-scale and offset, clamp to ADC range, scale to full D_W range.
  function automatic logic [31:0] model_cur(input int code, input int off);
    int half;
    int d;
    half = 2 ** (A_W - 1);
    d = code - half - off;
    if (d > half - 1) d = half - 1;
    if (d < -half)    d = -half;
    return 32'(d * (2 ** (D_W - A_W))) & 32'h0000_FFFF;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC responder: answers after ack_wait cycles, checks the A,B,C channel order, and
  // throws in stray acks while no request is pending.
  initial begin
    int wcnt;
    int exp_ch;
    wcnt = 0;
    exp_ch = 0;
    bus.adc_ack  = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(negedge clk);
      if (bus.adc_req) begin
        chk("adc_ch_seq", 32'(bus.adc_ch), 32'(exp_ch));
        if (wcnt >= ack_wait) begin
          bus.adc_ack  = 1'b1;
          bus.adc_data = A_W'(cur_code[exp_ch]);
          wcnt   = 0;
          exp_ch = (exp_ch + 1) % 3;
        end else begin
          bus.adc_ack  = 1'b0;
          bus.adc_data = A_W'($urandom);
          wcnt++;
        end
      end else begin
        bus.adc_ack  = 1'($urandom_range(0, 1));
        bus.adc_data = A_W'($urandom);
        wcnt   = 0;
        exp_ch = 0;
      end
    end
  end

  task automatic do_reset();
    rstb         = 1'b0;
    trigger      = 1'b0;
    bus.ready_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.adc_req), 0);
    chk("rst_valid", 32'(bus.valid_out), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_angle", 32'(bus.angle_out), 0);
    chk("rst_curr_a", 32'(bus.currA_out), 0);
    chk("rst_cal_done", 32'(cal_done), 32'(CAL_RST_EXP));
    exp_ovr = 1'b0;
    rstb = 1'b1;
  endtask

`ifdef OFFSET_CAL_EN
  task automatic wait_cal();
    int n;
    n = 0;
    while (!cal_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("cal_done_rise", 32'(cal_done), 1);
    for (int ch = 0; ch < 3; ch++) begin
      int sum;
      sum = 0;
      for (int r = 0; r < (1 << C_L); r++) sum += cur_code[ch] - 2 ** (A_W - 1);
      model_off[ch] = (sum >= 0) ? sum / (1 << C_L) : -((-sum + (1 << C_L) - 1) / (1 << C_L));
    end
  endtask
`endif

  // Caller is at a negedge; trigger is driven in the current cycle T.
  task automatic sample(input int c0, input int c1, input int c2, input int w, input int rdly,
                        input bit pre_rdy, input bit trig_hold, input bit trig_xfer);
    logic [D_W-1:0] ang;
    logic [31:0]    ea, eb, ec;
    int             t0, n;
    cur_code[0] = c0;
    cur_code[1] = c1;
    cur_code[2] = c2;
    ack_wait = w;
    ea = model_cur(c0, model_off[0]);
    eb = model_cur(c1, model_off[1]);
    ec = model_cur(c2, model_off[2]);
    bus.ready_in = pre_rdy;
    ang      = D_W'($urandom);
    angle_in = ang;
    trigger  = 1'b1;
    t0       = cyc;
    @(negedge clk);
    trigger  = 1'b0;
    angle_in = ~ang;
    chk("req_at_t1", {29'd0, bus.adc_req, bus.adc_ch}, 32'b100);
    n = 0;
    while (!bus.valid_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(cyc - t0), 32'(5 + 3 * w));
    chk("angle", 32'(bus.angle_out), 32'(ang));
    chk("curr_a", {16'd0, bus.currA_out}, ea);
    chk("curr_b", {16'd0, bus.currB_out}, eb);
    chk("curr_c", {16'd0, bus.currC_out}, ec);
    if (pre_rdy) begin
      @(negedge clk);
      chk("valid_one_cycle", 32'(bus.valid_out), 0);
    end else begin
      for (int i = 0; i < rdly; i++) begin
        trigger = trig_hold && (i == 0);
        @(negedge clk);
        chk("hold_valid", 32'(bus.valid_out), 1);
        chk("hold_curr_a", {16'd0, bus.currA_out}, ea);
        chk("hold_curr_c", {16'd0, bus.currC_out}, ec);
      end
      if (trig_hold && rdly > 0) exp_ovr = 1'b1;
      bus.ready_in = 1'b1;
      trigger      = trig_xfer;
      if (trig_xfer) exp_ovr = 1'b1;
      @(negedge clk);
      trigger      = 1'b0;
      bus.ready_in = 1'b0;
      chk("valid_drop", 32'(bus.valid_out), 0);
    end
    chk("no_new_conv", 32'(bus.adc_req), 0);
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    bus.ready_in = 1'b0;
    cur_code = '{1948, 1948, 1948};
    ack_wait = 0;
    do_reset();
`ifdef OFFSET_CAL_EN
    wait_cal();
`endif
    sample(2048, 3072, 1024, 0, 0, 1'b1, 1'b0, 1'b0);
    sample(2048, 3072, 1024, 3, 0, 1'b1, 1'b0, 1'b0);
    sample(1000, 2500, 3500, 0, 4, 1'b0, 1'b1, 1'b0);
    sample(4095, 0, 2047, 1, 0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      sample(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a conversion.
    cur_code = '{2058, 2058, 2058};
    ack_wait = 3;
    angle_in = D_W'($urandom);
    trigger  = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    chk("midconv_req", 32'(bus.adc_req), 1);
    rstb = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(bus.adc_req), 0);
    chk("midrst_valid", 32'(bus.valid_out), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    chk("midrst_cal_done", 32'(cal_done), 32'(CAL_RST_EXP));
    exp_ovr  = 1'b0;
    rstb     = 1'b1;
    ack_wait = 0;
`ifdef OFFSET_CAL_EN
    wait_cal();
`endif
    sample(2058, 2058, 2058, 0, 1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
